// File: rtl/ga_pkg.sv
// Shared types, constants and helpers for the geometric-algebra response unit.
// The optional GA_PERF_CNT_EN counters are exposed through ga_perf_counters_t.
package ga_pkg;

  localparam int GA_NUM_REGS = 32;
  localparam int GA_NUM_COMP = 8;
  localparam int GA_ADDR_W   = 6;

  localparam logic [2:0] GA_COMP_SCALAR    = 3'd0;
  localparam logic [2:0] GA_COMP_VECTOR_X  = 3'd1;
  localparam logic [2:0] GA_COMP_VECTOR_Y  = 3'd2;
  localparam logic [2:0] GA_COMP_VECTOR_Z  = 3'd3;
  localparam logic [2:0] GA_COMP_BIVEC_XY  = 3'd4;
  localparam logic [2:0] GA_COMP_BIVEC_XZ  = 3'd5;
  localparam logic [2:0] GA_COMP_BIVEC_YZ  = 3'd6;
  localparam logic [2:0] GA_COMP_TRIVECTOR = 3'd7;

  localparam logic [3:0] GA_FUNCT_ADD   = 4'd0;
  localparam logic [3:0] GA_FUNCT_SUB   = 4'd1;
  localparam logic [3:0] GA_FUNCT_MUL   = 4'd2;
  localparam logic [3:0] GA_FUNCT_GP    = 4'd3;
  localparam logic [3:0] GA_FUNCT_LOAD  = 4'd4;
  localparam logic [3:0] GA_FUNCT_STORE = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ga_resp_state_e;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           funct;
    logic [GA_ADDR_W-1:0] ga_reg_a;
    logic [GA_ADDR_W-1:0] ga_reg_b;
    logic [GA_ADDR_W-1:0] rd_addr;
    logic                 we;
    logic                 use_ga_regs;
    logic [31:0]          operand_a;
    logic [31:0]          operand_b;
  } ga_req_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        busy;
    logic        error;
    logic        overflow;
    logic        underflow;
    logic [31:0] result;
  } ga_resp_t;

  typedef struct packed {
    logic [31:0] ga_ops_total;
    logic [31:0] ga_ops_add;
    logic [31:0] ga_ops_mul;
    logic [31:0] ga_ops_geometric;
    logic [31:0] ga_cycles_busy;
    logic [31:0] ga_stalls;
  } ga_perf_counters_t;

  // Returns {overflow, underflow} for r = a +/- b; subtraction flips b's effective sign.
  function automatic logic [1:0] ga_ovf_unf(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] r, input logic sub);
    logic b_sign;
    b_sign = sub ? ~b[31] : b[31];
    ga_ovf_unf = {~a[31] & ~b_sign & r[31], a[31] & b_sign & ~r[31]};
  endfunction

endpackage

// File: rtl/ga_regfile.sv
// Multivector register file: NumRegs x 8 components x 32 bits, two combinational
// component read ports and one synchronous write port, cleared by async reset.
module ga_regfile
  import ga_pkg::*;
#(
  parameter int NumRegs = GA_NUM_REGS,
  parameter int AddrW   = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] i_a_idx,
  input  logic [2:0]       i_a_comp,
  output logic [31:0]      o_a_data,
  input  logic [AddrW-1:0] i_b_idx,
  input  logic [2:0]       i_b_comp,
  output logic [31:0]      o_b_data,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_w_idx,
  input  logic [2:0]       i_w_comp,
  input  logic [31:0]      i_w_data
);

  logic [31:0] r_mem [NumRegs][GA_NUM_COMP];

  // Storage array with a single synchronous write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) begin
        for (int c = 0; c < GA_NUM_COMP; c++) begin
          r_mem[r][c] <= 32'd0;
        end
      end
    end else if (i_we && (int'(i_w_idx) < NumRegs)) begin
      r_mem[i_w_idx][i_w_comp] <= i_w_data;
    end
  end

  assign o_a_data = (int'(i_a_idx) < NumRegs) ? r_mem[i_a_idx][i_a_comp] : 32'd0;
  assign o_b_data = (int'(i_b_idx) < NumRegs) ? r_mem[i_b_idx][i_b_comp] : 32'd0;

endmodule

// File: rtl/ga_resp_unit.sv
// GA response unit: LOAD/STORE single components, ADD/SUB whole multivectors one
// component per cycle. Define GA_PERF_CNT_EN to build the performance counters.
module ga_resp_unit
  import ga_pkg::*;
#(
  parameter int NumRegs = GA_NUM_REGS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  ga_req_t           req_i,
  output ga_resp_t          resp_o,
  output ga_perf_counters_t perf_o
);

  localparam int AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  ga_resp_state_e r_state, w_state_nxt;
  ga_req_t        r_req;
  logic [2:0]     r_k;
  logic [31:0]    r_result;
  logic           r_error, r_ovf, r_unf;

  logic             w_ready, w_accept, w_range_err, w_is_addsub, w_known, w_sub, w_we;
  logic [AddrW-1:0] w_a_idx, w_w_idx;
  logic [2:0]       w_a_comp, w_w_comp;
  logic [31:0]      w_a_data, w_b_data, w_w_data, w_sum;
  logic [1:0]       w_flags;
  logic             w_unused;

  assign w_ready     = (r_state == IDLE);
  assign w_accept    = req_i.valid && w_ready;
  assign w_range_err = (int'(req_i.ga_reg_a) >= NumRegs) || (int'(req_i.ga_reg_b) >= NumRegs)
                       || (int'(req_i.rd_addr) >= NumRegs);
  assign w_is_addsub = (req_i.funct == GA_FUNCT_ADD) || (req_i.funct == GA_FUNCT_SUB);
  assign w_known     = w_is_addsub || (req_i.funct == GA_FUNCT_LOAD)
                       || (req_i.funct == GA_FUNCT_STORE);
  assign w_sub       = (r_req.funct == GA_FUNCT_SUB);
  assign w_sum       = w_sub ? (w_a_data - w_b_data) : (w_a_data + w_b_data);
  assign w_flags     = ga_ovf_unf(w_a_data, w_b_data, w_sum, w_sub);
  assign w_unused    = ^{r_req, req_i};

  ga_regfile #(.NumRegs(NumRegs), .AddrW(AddrW)) u_regfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_a_idx  (w_a_idx),
    .i_a_comp (w_a_comp),
    .o_a_data (w_a_data),
    .i_b_idx  (r_req.ga_reg_b[AddrW-1:0]),
    .i_b_comp (r_k),
    .o_b_data (w_b_data),
    .i_we     (w_we),
    .i_w_idx  (w_w_idx),
    .i_w_comp (w_w_comp),
    .i_w_data (w_w_data)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and register-file port steering; IDLE reads/writes straight from req_i.
  always_comb begin
    w_state_nxt = r_state;
    w_a_idx     = r_req.ga_reg_a[AddrW-1:0];
    w_a_comp    = r_k;
    w_we        = 1'b0;
    w_w_idx     = r_req.rd_addr[AddrW-1:0];
    w_w_comp    = r_k;
    w_w_data    = w_sum;
    case (r_state)
      IDLE: begin
        w_a_idx  = req_i.ga_reg_a[AddrW-1:0];
        w_a_comp = req_i.operand_b[2:0];
        if (w_accept) begin
          w_state_nxt = (!w_range_err && w_is_addsub) ? EXEC : RESP;
          if (!w_range_err && (req_i.funct == GA_FUNCT_STORE) && req_i.we) begin
            w_we     = 1'b1;
            w_w_idx  = req_i.rd_addr[AddrW-1:0];
            w_w_comp = req_i.operand_b[2:0];
            w_w_data = req_i.operand_a;
          end else begin
            w_we = 1'b0;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: begin
        w_we        = r_req.we;
        w_state_nxt = (r_k == 3'd7) ? RESP : EXEC;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, component sequencing, result and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req    <= '0;
      r_k      <= 3'd0;
      r_result <= 32'd0;
      r_error  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req   <= req_i;
            r_k     <= 3'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_error <= w_range_err || !w_known;
            if (w_range_err) begin
              r_result <= 32'd0;
            end else if (req_i.funct == GA_FUNCT_LOAD) begin
              r_result <= w_a_data;
            end else if (req_i.funct == GA_FUNCT_STORE) begin
              r_result <= req_i.operand_a;
            end else begin
              r_result <= 32'd0;
            end
          end
        end
        EXEC: begin
          r_k   <= r_k + 3'd1;
          r_ovf <= r_ovf | w_flags[1];
          r_unf <= r_unf | w_flags[0];
          if (r_k == 3'd0) begin
            r_result <= w_sum;
          end
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

  // Response decode; payload fields are zero outside the RESP cycle.
  always_comb begin
    resp_o           = '0;
    resp_o.ready     = (r_state == IDLE);
    resp_o.busy      = (r_state == EXEC);
    resp_o.valid     = (r_state == RESP);
    resp_o.error     = (r_state == RESP) & r_error;
    resp_o.overflow  = (r_state == RESP) & r_ovf;
    resp_o.underflow = (r_state == RESP) & r_unf;
    resp_o.result    = (r_state == RESP) ? r_result : 32'd0;
  end

`ifdef GA_PERF_CNT_EN
  logic [31:0] r_ops_total, r_ops_add, r_cycles_busy, r_stalls;

  // Event counters, all wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ops_total   <= 32'd0;
      r_ops_add     <= 32'd0;
      r_cycles_busy <= 32'd0;
      r_stalls      <= 32'd0;
    end else begin
      if (w_accept) r_ops_total <= r_ops_total + 32'd1;
      if (w_accept && w_is_addsub) r_ops_add <= r_ops_add + 32'd1;
      if (r_state == EXEC) r_cycles_busy <= r_cycles_busy + 32'd1;
      if (req_i.valid && !w_ready) r_stalls <= r_stalls + 32'd1;
    end
  end

  // Counter output packing onto the perf_o structure.
  always_comb begin
    perf_o                = '0;
    perf_o.ga_ops_total   = r_ops_total;
    perf_o.ga_ops_add     = r_ops_add;
    perf_o.ga_cycles_busy = r_cycles_busy;
    perf_o.ga_stalls      = r_stalls;
  end
`else
  assign perf_o = '0;
`endif

endmodule

// File: tb/tb_ga_resp_unit.sv
// Directed self-checking bench for ga_resp_unit with hand-computed expectations.
module tb_ga_resp_unit;
  import ga_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  ga_req_t           req_i;
  ga_resp_t          resp_o;
  ga_perf_counters_t perf_o;

  int       checks = 0;
  int       errors = 0;
  ga_resp_t last_resp;
  int       last_lat;
  int       last_busy;
  ga_resp_t idle_resp;

  ga_resp_unit #(.NumRegs(GA_NUM_REGS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .resp_o (resp_o),
    .perf_o (perf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request, then wait (bounded) for its response pulse.
  task automatic issue(input logic [3:0] funct, input logic [5:0] ra, input logic [5:0] rb,
                       input logic [5:0] rd, input logic we, input logic [31:0] opa,
                       input logic [31:0] opb);
    int budget;
    budget = 0;
    @(negedge clk_i);
    while (!resp_o.ready && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    check_eq("ready_before_issue", 64'(resp_o.ready), 64'd1);
    req_i             = '0;
    req_i.funct       = funct;
    req_i.ga_reg_a    = ra;
    req_i.ga_reg_b    = rb;
    req_i.rd_addr     = rd;
    req_i.we          = we;
    req_i.operand_a   = opa;
    req_i.operand_b   = opb;
    req_i.use_ga_regs = 1'b0;
    req_i.valid       = 1'b1;
    @(posedge clk_i);
    #1;
    req_i.valid = 1'b0;
    last_lat  = 0;
    last_busy = 0;
    last_resp = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      if (resp_o.valid) begin
        last_resp = resp_o;
        last_lat  = c;
        break;
      end
      if (resp_o.busy) last_busy++;
    end
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [31:0] result,
                             input logic err, input logic ovf, input logic unf);
    check_eq({tag, "_lat"}, 64'(last_lat), 64'(lat));
    check_eq({tag, "_result"}, 64'(last_resp.result), 64'(result));
    check_eq({tag, "_err_ovf_unf"},
             64'({last_resp.error, last_resp.overflow, last_resp.underflow}),
             64'({err, ovf, unf}));
  endtask

  task automatic store(input string tag, input logic [5:0] rd, input logic [2:0] comp,
                       input logic [31:0] data, input logic we);
    issue(GA_FUNCT_STORE, 6'd0, 6'd0, rd, we, data, {29'd0, comp});
    expect_resp(tag, 1, data, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [5:0] ra, input logic [31:0] opb,
                      input logic [31:0] exp);
    issue(GA_FUNCT_LOAD, ra, 6'd0, 6'd0, 1'b0, 32'd0, opb);
    expect_resp(tag, 1, exp, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int low;
    int seen_valid;
    logic [31:0] stalls0;
    idle_resp       = '0;
    idle_resp.ready = 1'b1;
    stalls0         = 32'd0;
    rst_ni          = 1'b0;
    req_i           = '0;

    repeat (2) @(negedge clk_i);
    check_eq("reset_resp", 64'(resp_o), 64'(idle_resp));
    check_eq("reset_perf_stalls", 64'(perf_o.ga_stalls), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("post_reset_resp", 64'(resp_o), 64'(idle_resp));

    // Signed overflow on the scalar component.
    store("st_r1c0", 6'd1, GA_COMP_SCALAR, 32'h7FFF_FFFF, 1'b1);
    store("st_r2c0", 6'd2, GA_COMP_SCALAR, 32'h0000_0001, 1'b1);
    issue(GA_FUNCT_ADD, 6'd1, 6'd2, 6'd3, 1'b1, 32'd0, 32'd0);
    expect_resp("add_ovf", 9, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    check_eq("add_ovf_busy_cycles", 64'(last_busy), 64'd8);
    load("ld_r3c0", 6'd3, 32'd0, 32'h8000_0000);

    // Signed underflow on a bivector component, operand_b upper bits ignored.
    store("st_r4c5", 6'd4, GA_COMP_BIVEC_XZ, 32'h8000_0000, 1'b1);
    store("st_r5c5", 6'd5, GA_COMP_BIVEC_XZ, 32'h0000_0001, 1'b1);
    issue(GA_FUNCT_SUB, 6'd4, 6'd5, 6'd4, 1'b1, 32'd0, 32'd0);
    expect_resp("sub_unf", 9, 32'd0, 1'b0, 1'b0, 1'b1);
    load("ld_r4c5", 6'd4, 32'd5, 32'h7FFF_FFFF);
    load("ld_r4c5_hi", 6'd4, 32'hFFFF_FFF5, 32'h7FFF_FFFF);

    // Unsupported funct and out-of-range addresses.
    issue(GA_FUNCT_MUL, 6'd4, 6'd5, 6'd4, 1'b1, 32'h1234_5678, 32'd5);
    expect_resp("mul_err", 1, 32'd0, 1'b1, 1'b0, 1'b0);
    load("ld_r4c5_after_mul", 6'd4, 32'd5, 32'h7FFF_FFFF);
    issue(GA_FUNCT_LOAD, 6'd32, 6'd0, 6'd0, 1'b0, 32'd0, 32'd0);
    expect_resp("ld_range_err", 1, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(GA_FUNCT_STORE, 6'd0, 6'd0, 6'd40, 1'b1, 32'h0000_DEAD, 32'd0);
    expect_resp("st_range_err", 1, 32'd0, 1'b1, 1'b0, 1'b0);
    load("ld_r8c0_untouched", 6'd8, 32'd0, 32'd0);
    store("st_r31c7", 6'd31, GA_COMP_TRIVECTOR, 32'h0000_CAFE, 1'b1);
    load("ld_r31c7", 6'd31, 32'd7, 32'h0000_CAFE);

    // we=0 suppresses writes for both ADD and STORE.
    issue(GA_FUNCT_ADD, 6'd1, 6'd2, 6'd7, 1'b0, 32'd0, 32'd0);
    expect_resp("add_nowe", 9, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    load("ld_r7c0_nowe", 6'd7, 32'd0, 32'd0);
    store("st_nowe", 6'd8, GA_COMP_VECTOR_X, 32'h0000_1234, 1'b0);
    load("ld_r8c1_nowe", 6'd8, 32'd1, 32'd0);

    // Full aliasing rd=a=b: every component doubles in place.
    for (int k = 0; k < 8; k++) store("st_r6", 6'd6, 3'(k), 32'(k + 1), 1'b1);
    issue(GA_FUNCT_ADD, 6'd6, 6'd6, 6'd6, 1'b1, 32'd0, 32'd0);
    expect_resp("add_alias", 9, 32'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) load("ld_r6_alias", 6'd6, 32'(k), 32'(2 * (k + 1)));

    // Request held valid through an ADD; the follow-up LOAD waits for IDLE.
    @(negedge clk_i);
`ifdef GA_PERF_CNT_EN
    stalls0 = perf_o.ga_stalls;
`endif
    req_i          = '0;
    req_i.funct    = GA_FUNCT_ADD;
    req_i.ga_reg_a = 6'd6;
    req_i.ga_reg_b = 6'd6;
    req_i.rd_addr  = 6'd9;
    req_i.we       = 1'b1;
    req_i.valid    = 1'b1;
    @(posedge clk_i);
    #1;
    req_i           = '0;
    req_i.funct     = GA_FUNCT_LOAD;
    req_i.ga_reg_a  = 6'd9;
    req_i.operand_b = 32'd7;
    req_i.valid     = 1'b1;
    low = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (resp_o.ready) break;
      low++;
    end
    check_eq("hold_ready_low_cycles", 64'(low), 64'd9);
    @(posedge clk_i);
    #1;
    req_i.valid = 1'b0;
    @(negedge clk_i);
    check_eq("hold_second_valid", 64'(resp_o.valid), 64'd1);
    check_eq("hold_second_result", 64'(resp_o.result), 64'd32);
`ifdef GA_PERF_CNT_EN
    check_eq("perf_stalls", 64'(perf_o.ga_stalls - stalls0), 64'd9);
    check_eq("perf_ops_mul", 64'(perf_o.ga_ops_mul), 64'd0);
`else
    check_eq("perf_tied_zero", 64'(perf_o), 64'd0);
`endif

    // Reset in the middle of EXEC (component k=3) abandons the operation.
    @(negedge clk_i);
    req_i          = '0;
    req_i.funct    = GA_FUNCT_ADD;
    req_i.ga_reg_a = 6'd6;
    req_i.ga_reg_b = 6'd6;
    req_i.rd_addr  = 6'd10;
    req_i.we       = 1'b1;
    req_i.valid    = 1'b1;
    @(posedge clk_i);
    #1;
    req_i.valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni     = 1'b0;
    seen_valid = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (resp_o.valid) seen_valid++;
    end
    check_eq("mid_reset_resp", 64'(resp_o), 64'(idle_resp));
    rst_ni = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (resp_o.valid) seen_valid++;
    end
    check_eq("mid_reset_no_valid", 64'(seen_valid), 64'd0);
    check_eq("mid_reset_ready", 64'(resp_o.ready), 64'd1);
    load("ld_r10c0_after_reset", 6'd10, 32'd0, 32'd0);
    load("ld_r6c3_after_reset", 6'd6, 32'd3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
